// File: rtl/prog_clk_div.sv
// prog_clk_div
//   Multi-channel runtime-programmable clock divider. Each channel divides i_clk
//   by its active divisor D (D >= 2), producing a ~50% duty clock that is high
//   for ceil(D/2) cycles and a one-cycle tick on the first cycle of each period.
//   New divisors are held as pending and take effect only at a period boundary,
//   so a running period is never cut short. i_sync restarts every enabled channel
//   on the same edge, which phase-aligns all outputs.
//
// Ports
//   i_clk     system clock
//   i_rst     synchronous reset, active-high, dominates all other inputs
//   i_wr_en   divisor write strobe (one write per asserted cycle)
//   i_wr_ch   target channel of the write; out-of-range values are ignored
//   i_wr_div  new divisor; values below 2 disable the channel
//   i_sync    restart all enabled channels' periods on this edge
//   o_clk     divided clock, one bit per channel (registered)
//   o_tick    one-cycle pulse on the first cycle of each period (registered)
//   o_pend    channel holds a written but not yet applied divisor (registered)
module prog_clk_div #(
  parameter  int N_CH    = 4,
  parameter  int WIDTH   = 16,
  parameter  int DEF_DIV = 7,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [CH_W-1:0]   i_wr_ch,
  input  logic [WIDTH-1:0]  i_wr_div,
  input  logic              i_sync,
  output logic [N_CH-1:0]   o_clk,
  output logic [N_CH-1:0]   o_tick,
  output logic [N_CH-1:0]   o_pend
);

  function automatic logic div_enabled(input logic [WIDTH-1:0] d);
    return d >= WIDTH'(2);
  endfunction

  // High phase is ceil(D/2) cycles; computed one bit wider so D = 2**WIDTH-1
  // cannot overflow.
  function automatic logic clk_level(input logic [WIDTH-1:0] d,
                                     input logic [WIDTH-1:0] n);
    logic [WIDTH:0] high_len;
    high_len = ({1'b0, d} + (WIDTH+1)'(1)) >> 1;
    return div_enabled(d) && ({1'b0, n} < high_len);
  endfunction

  logic                started_p0;
  logic [WIDTH-1:0]    cnt_p0   [N_CH];
  logic [WIDTH-1:0]    div_p0   [N_CH];
  logic [WIDTH-1:0]    pdiv_p0  [N_CH];
  logic [N_CH-1:0]     pend_p0;
  logic [N_CH-1:0]     clk_p0;
  logic [N_CH-1:0]     tick_p0;

  logic [WIDTH-1:0]    cnt_nxt  [N_CH];
  logic [WIDTH-1:0]    div_nxt  [N_CH];
  logic [WIDTH-1:0]    pdiv_nxt [N_CH];
  logic [N_CH-1:0]     pend_nxt;
  logic [N_CH-1:0]     clk_nxt;
  logic [N_CH-1:0]     tick_nxt;
  logic [N_CH-1:0]     wr_hit;
  logic [N_CH-1:0]     boundary;

  // Next-state for every channel. A boundary edge is one that begins a new
  // period: the first edge after reset, a sync edge, the wrap edge of a running
  // period, or any edge of a disabled channel (so a pending divisor written to
  // an idle channel takes effect on the following edge). Only boundaries may
  // promote the pending divisor. A write on a boundary edge lands in pending
  // and waits for the next boundary, since the promotion uses the pending
  // register as it was before this edge.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      cnt_nxt[c]  = cnt_p0[c];
      div_nxt[c]  = div_p0[c];
      pdiv_nxt[c] = pdiv_p0[c];
      pend_nxt[c] = pend_p0[c];
      // Out-of-range channel numbers match no channel index, so they are dropped.
      wr_hit[c]   = i_wr_en && (i_wr_ch == CH_W'(c));
      boundary[c] = !started_p0 || i_sync || !div_enabled(div_p0[c]) ||
                    (cnt_p0[c] == div_p0[c] - WIDTH'(1));

      if (boundary[c]) begin
        if (pend_p0[c]) begin
          div_nxt[c] = pdiv_p0[c];
        end
        pend_nxt[c] = 1'b0;
        cnt_nxt[c]  = '0;
      end else begin
        cnt_nxt[c]  = cnt_p0[c] + WIDTH'(1);
      end

      if (wr_hit[c]) begin
        pdiv_nxt[c] = i_wr_div;
        pend_nxt[c] = 1'b1;
      end

      clk_nxt[c]  = clk_level(div_nxt[c], cnt_nxt[c]);
      tick_nxt[c] = div_enabled(div_nxt[c]) && (cnt_nxt[c] == '0);
    end
  end

  // Stage p0: registered channel state and outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      started_p0 <= 1'b0;
      pend_p0    <= '0;
      clk_p0     <= '0;
      tick_p0    <= '0;
      for (int c = 0; c < N_CH; c++) begin
        cnt_p0[c] <= '0;
        div_p0[c] <= WIDTH'(DEF_DIV);
      end
    end else begin
      started_p0 <= 1'b1;
      pend_p0    <= pend_nxt;
      clk_p0     <= clk_nxt;
      tick_p0    <= tick_nxt;
      for (int c = 0; c < N_CH; c++) begin
        cnt_p0[c] <= cnt_nxt[c];
        div_p0[c] <= div_nxt[c];
      end
    end
  end

  // Pending divisor is data only; it is qualified by pend_p0, so it needs no reset.
  always_ff @(posedge i_clk) begin
    for (int c = 0; c < N_CH; c++) begin
      pdiv_p0[c] <= pdiv_nxt[c];
    end
  end

  assign o_clk  = clk_p0;
  assign o_tick = tick_p0;
  assign o_pend = pend_p0;

endmodule

// File: tb/tb_prog_clk_div.sv
module tb_prog_clk_div;

  localparam int N_CH    = 3;
  localparam int WIDTH   = 16;
  localparam int DEF_DIV = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [1:0]        wr_ch;
  logic [WIDTH-1:0]  wr_div;
  logic              sync;
  logic [N_CH-1:0]   o_clk;
  logic [N_CH-1:0]   o_tick;
  logic [N_CH-1:0]   o_pend;

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_q [$];

  // Reference model state
  int m_cnt  [N_CH];
  int m_div  [N_CH];
  int m_pdiv [N_CH];
  bit m_pend [N_CH];
  bit m_started;

  always #5 clk = ~clk;

  prog_clk_div #(.N_CH(N_CH), .WIDTH(WIDTH), .DEF_DIV(DEF_DIV)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_wr_en (wr_en),
    .i_wr_ch (wr_ch),
    .i_wr_div(wr_div),
    .i_sync  (sync),
    .o_clk   (o_clk),
    .o_tick  (o_tick),
    .o_pend  (o_pend)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance the model by one edge using the currently driven inputs and push
  // the expected {clk, tick, pend} vectors for the sample after that edge.
  task automatic model_push();
    logic [2:0] ec, et, ep;
    bit start;
    ec = '0; et = '0; ep = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (rst) begin
        m_cnt[c]  = 0;
        m_div[c]  = DEF_DIV;
        m_pend[c] = 1'b0;
      end else begin
        start = !m_started || sync || (m_div[c] < 2) || (m_cnt[c] == m_div[c] - 1);
        if (start) begin
          if (m_pend[c]) m_div[c] = m_pdiv[c];
          m_pend[c] = 1'b0;
          m_cnt[c]  = 0;
        end else begin
          m_cnt[c]  = m_cnt[c] + 1;
        end
        if (wr_en && (int'(wr_ch) == c)) begin
          m_pdiv[c] = int'(wr_div);
          m_pend[c] = 1'b1;
        end
        ec[c] = (m_div[c] >= 2) && (m_cnt[c] < (m_div[c] + 1) / 2);
        et[c] = (m_div[c] >= 2) && (m_cnt[c] == 0);
        ep[c] = m_pend[c];
      end
    end
    m_started = !rst;
    exp_q.push_back({ec, et, ep});
  endtask

  task automatic cycle();
    logic [8:0] e;
    model_push();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("sb_clk",  32'(o_clk),  32'(e[8:6]));
    check("sb_tick", 32'(o_tick), 32'(e[5:3]));
    check("sb_pend", 32'(o_pend), 32'(e[2:0]));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic write(input logic [1:0] ch, input logic [WIDTH-1:0] d);
    wr_en  = 1'b1;
    wr_ch  = ch;
    wr_div = d;
    cycle();
    wr_en  = 1'b0;
  endtask

  // Advance until the current sample shows a tick on channel ch.
  task automatic wait_tick(input int ch, input int budget, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (o_tick[ch]) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    if (!found && o_tick[ch]) found = 1'b1;
    check(tag, 32'(found), 32'(1));
  endtask

  // Capture n samples of o_clk[ch], starting with the current sample.
  task automatic capture(input int ch, input int n, output logic [31:0] pat);
    pat = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) cycle();
      pat = {pat[30:0], o_clk[ch]};
    end
  endtask

  initial begin
    logic [13:0] pc, pt;
    logic [31:0] pat;

    rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_div = '0; sync = 1'b0;
    run(2);
    check("rst_clk",  32'(o_clk),  32'(0));
    check("rst_tick", 32'(o_tick), 32'(0));
    check("rst_pend", 32'(o_pend), 32'(0));

    // Default divisor 7 from start-up
    rst = 1'b0;
    pc = '0; pt = '0;
    for (int i = 0; i < 14; i++) begin
      cycle();
      pc = {pc[12:0], o_clk[0]};
      pt = {pt[12:0], o_tick[0]};
    end
    check("t1_clk_pattern",  32'(pc), 32'(14'b11110001111000));
    check("t1_tick_pattern", 32'(pt), 32'(14'b10000001000000));

    // D=6 on ch1 written mid-period, applied at the next boundary
    run(2);
    write(2'd1, 16'd6);
    check("t2_pend_set", 32'(o_pend[1]), 32'(1));
    wait_tick(1, 20, "t2_apply_tick");
    check("t2_pend_clr", 32'(o_pend[1]), 32'(0));
    capture(1, 12, pat);
    check("t2_pattern", pat, 32'(12'b111000111000));

    // D=4 on ch0 written so that cnt=2 is the first sample after the write
    wait_tick(0, 20, "t3_sync_tick");
    cycle();
    write(2'd0, 16'd4);
    capture(0, 13, pat);
    check("t3_pattern", pat, 32'(13'b1100011001100));

    // Disable ch2, then re-enable with D=5
    write(2'd2, 16'd0);
    run(16);
    check("t4_idle_clk",  32'(o_clk[2]),  32'(0));
    check("t4_idle_tick", 32'(o_tick[2]), 32'(0));
    check("t4_idle_pend", 32'(o_pend[2]), 32'(0));
    write(2'd2, 16'd5);
    check("t4_pend_set", 32'(o_pend[2]), 32'(1));
    check("t4_still_low", 32'(o_clk[2]), 32'(0));
    cycle();
    check("t4_start_tick", 32'(o_tick[2]), 32'(1));
    check("t4_pend_clr",   32'(o_pend[2]), 32'(0));
    capture(2, 10, pat);
    check("t4_pattern", pat, 32'(10'b1110011100));

    // D=3,5,8 then sync
    write(2'd0, 16'd3);
    write(2'd1, 16'd5);
    write(2'd2, 16'd8);
    run(20);
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    check("t5_tick_aligned", 32'(o_tick), 32'(3'b111));
    check("t5_clk_aligned",  32'(o_clk),  32'(3'b111));
    capture(0, 6, pat);
    check("t5_ch0_pattern", pat, 32'(6'b110110));

    // Reset mid-period with an out-of-range write
    run(3);
    rst = 1'b1; wr_en = 1'b1; wr_ch = 2'd3; wr_div = 16'd2;
    cycle();
    check("t6_rst_clk",  32'(o_clk),  32'(0));
    check("t6_rst_tick", 32'(o_tick), 32'(0));
    check("t6_rst_pend", 32'(o_pend), 32'(0));
    rst = 1'b0;
    cycle();
    check("t6_restart_clk",  32'(o_clk),  32'(3'b111));
    check("t6_restart_tick", 32'(o_tick), 32'(3'b111));
    check("t6_oor_pend",     32'(o_pend), 32'(0));
    wr_en = 1'b0;
    run(4);
    check("t6_oor_pend_hold", 32'(o_pend), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
